carfield_l2_port_arbiter: RTL and testbench
===========================================

CARFIELD_L2_PORT_ARBITER -- requirements
Module: carfield_l2_port_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4: number of requesters.
REQ-002 SHALL have parameter IdFifoDepth, default 4: outstanding transactions per L2 port.
REQ-003 SHALL have parameter L2Port0Base, default 'h7800_0000: port 0 base address.
REQ-004 SHALL have parameter L2PortSize, default 'h0020_0000: size of each port; port 1 base = L2Port0Base + L2PortSize.
REQ-005 SHALL have port clk_i, input, 1: single clock; all state is clocked on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port req_i, input, NumReq x 1: per-requester request.
REQ-008 SHALL have port addr_i, input, NumReq x 64: byte address.
REQ-009 SHALL have port we_i / wdata_i / be_i, input, NumReq x (1 / 64 / 8): write enable, write data, byte enables.
REQ-010 SHALL have port gnt_o, output, NumReq x 1: request accepted.
REQ-011 SHALL have port rvalid_o / rdata_o / err_o, output, NumReq x (1 / 64 / 1): response.
REQ-012 SHALL have port l2_req_o / l2_addr_o / l2_we_o / l2_wdata_o / l2_be_o, output, 2 x (1 / 21 / 1 / 64 / 8): per-L2-port request; the address is the offset from the port base.
REQ-013 SHALL have port l2_gnt_i / l2_rvalid_i / l2_rdata_i, input, 2 x (1 / 1 / 64): per-L2-port grant and in-order response.

Function
REQ-014 SHALL decode each request as port 0 (L2Port0Base <= addr < L2Port0Base+L2PortSize), port 1 (the next L2PortSize bytes), or out-of-range.
REQ-015 SHALL arbitrate each port independently, round-robin, among eligible requesters targeting it; eligible = req_i high AND no outstanding response.
REQ-016 SHALL drive the request combinationally: l2_req_o high and the winner's fields muxed in the same cycle; gnt_o[winner] = l2_gnt_i AND l2_req_o.
REQ-017 SHALL set the RR pointer to winner+1 (mod NumReq) only on an l2_req_o AND l2_gnt_i handshake; pointer held otherwise.
REQ-018 SHALL hold l2_req_o low while the port's ID FIFO is full.
REQ-019 SHALL push the winner index into the port ID FIFO on handshake; on l2_rvalid_i, pop the FIFO head and assert rvalid_o[head] with rdata_o = l2_rdata_i and err_o = 0 in the same cycle.
REQ-020 SHALL support a simultaneous push and pop on a full FIFO; the FIFO then stays full.
REQ-021 SHALL ignore l2_rvalid_i when the ID FIFO is empty (no rvalid_o).
REQ-022 SHALL grant an out-of-range request from an eligible requester in the same cycle, without touching any L2 port, then give rvalid_o=1, err_o=1, rdata_o=0 on the next cycle.
REQ-023 SHALL allow one outstanding transaction per requester; the busy flag sets on grant and clears on its rvalid_o; a new request may be granted in the cycle after that rvalid_o.
REQ-024 SHALL allow both ports to grant different requesters and return responses in the same cycle.
REQ-025 SHALL drive rdata_o = 0 when rvalid_o is low.

Reset
REQ-026 SHALL, while rst_i is high: clear both RR pointers to 0, empty both ID FIFOs, clear busy flags and pending errors; gnt_o, rvalid_o, err_o and l2_req_o are all 0.
REQ-027 SHALL, on a reset mid-operation, drop in-flight transactions; later L2 responses are ignored per REQ-021.

Structure
REQ-028 SHALL place the per-requester and per-L2-port request/response struct typedefs and the L2 offset width (21) in package carfield_l2arb_pkg; default base and size values are taken from carfield_configuration.
REQ-029 SHALL implement the per-port RR arbiter and ID FIFO as sub-module carfield_l2_port_sched, instantiated twice.

Verification
REQ-030 SHALL cover: req 0-3 all to 'h7800_0040 with l2_gnt_i=1 -> grants in order 0,1,2,3, one per cycle; l2_addr_o='h40.
REQ-031 SHALL cover: req0 to 'h7800_0000 and req1 to 'h7820_0010 in the same cycle -> both granted in that cycle; l2_addr_o[1]='h10.
REQ-032 SHALL cover: req2 to 'h8000_0000 -> gnt same cycle, no l2_req_o, next cycle rvalid_o[2]=1, err_o[2]=1.
REQ-033 SHALL cover: 4 grants on port 0 with l2_rvalid_i held low -> 5th request not issued; one l2_rvalid_i -> issued; rvalid_o routed to the first grantee.
REQ-034 SHALL cover: rst_i asserted with 2 outstanding, then l2_rvalid_i pulses -> no rvalid_o; next request is granted to requester 0 first.
REQ-035 SHALL cover: req1 busy, req1 reasserts -> no gnt until the cycle after its rvalid_o.

Source files
------------

// File: rtl/carfield_configuration.sv
// carfield_configuration
//   Platform-wide address map constants shared by Carfield blocks.
//   Only the L2 port window is needed by the L2 port arbiter.
package carfield_configuration;

  localparam logic [63:0] CarfieldL2Port0Base = 64'h0000_0000_7800_0000;
  localparam logic [63:0] CarfieldL2PortSize  = 64'h0000_0000_0020_0000;

endpackage

// File: rtl/carfield_l2arb_pkg.sv
// carfield_l2arb_pkg
//   Types and constants for the Carfield L2 port arbiter.
//   - req_port_t / rsp_port_t : per-requester request / response bundles
//   - l2_req_t / l2_rsp_t     : per-L2-port request / response bundles
//   - decode_target()         : maps a byte address to port 0, port 1 or none
package carfield_l2arb_pkg;

  localparam int unsigned L2OffsetWidth = 21;

  typedef enum logic [1:0] {
    TGT_PORT0 = 2'd0,
    TGT_PORT1 = 2'd1,
    TGT_NONE  = 2'd2
  } tgt_e;

  typedef struct packed {
    logic        req;
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [7:0]  be;
  } req_port_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [63:0] rdata;
    logic        err;
  } rsp_port_t;

  typedef struct packed {
    logic                     req;
    logic [L2OffsetWidth-1:0] addr;
    logic                     we;
    logic [63:0]              wdata;
    logic [7:0]               be;
  } l2_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [63:0] rdata;
  } l2_rsp_t;

  // Port 1 occupies the window directly above port 0.
  function automatic tgt_e decode_target(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] size);
    if ((addr >= base) && (addr < base + size)) begin
      return TGT_PORT0;
    end else if ((addr >= base + size) && (addr < base + size + size)) begin
      return TGT_PORT1;
    end
    return TGT_NONE;
  endfunction

endpackage

// File: rtl/carfield_l2_port_sched.sv
// carfield_l2_port_sched
//   Per-L2-port scheduler: round-robin arbiter over the requesters targeting
//   this port plus an ID FIFO that remembers who owns each in-order response.
//   Ports:
//     clk_i, rst_i   : clock, asynchronous active-high reset
//     req_i          : eligible requesters targeting this port
//     gnt_o          : one-hot grant (request accepted by the L2 port)
//     req_o          : request towards the L2 port
//     winner_o       : index of the requester whose fields are presented
//     l2_gnt_i       : L2 port grant
//     l2_rvalid_i    : L2 port response valid
//     rsp_valid_o    : response routed to requester rsp_id_o this cycle
//     rsp_id_o       : owner of the oldest outstanding transaction
module carfield_l2_port_sched #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned Depth  = 4,
  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic              req_o,
  output logic [IdxW-1:0]   winner_o,
  input  logic              l2_gnt_i,
  input  logic              l2_rvalid_i,
  output logic              rsp_valid_o,
  output logic [IdxW-1:0]   rsp_id_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [IdxW-1:0] rr_ptr_reg;
  logic [IdxW-1:0] fifo_mem_reg [Depth];
  logic [PtrW-1:0] wr_ptr_reg;
  logic [PtrW-1:0] rd_ptr_reg;
  logic [CntW-1:0] count_reg;

  logic            any_req;
  logic [IdxW-1:0] winner;
  logic [IdxW:0]   cand_sum;
  logic [IdxW-1:0] cand;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  // Scan requesters starting at the RR pointer; first hit wins.
  always_comb begin
    any_req  = 1'b0;
    winner   = rr_ptr_reg;
    cand_sum = '0;
    cand     = '0;
    for (int k = 0; k < int'(NumReq); k++) begin
      cand_sum = {1'b0, rr_ptr_reg} + (IdxW+1)'(k);
      if (cand_sum >= (IdxW+1)'(NumReq)) begin
        cand_sum = cand_sum - (IdxW+1)'(NumReq);
      end
      cand = cand_sum[IdxW-1:0];
      if (!any_req && req_i[cand]) begin
        any_req = 1'b1;
        winner  = cand;
      end
    end
  end

  assign full        = (count_reg == CntW'(Depth));
  assign empty       = (count_reg == '0);
  assign req_o       = any_req & ~full;
  assign winner_o    = winner;
  assign push        = req_o & l2_gnt_i;
  assign pop         = l2_rvalid_i & ~empty;
  assign rsp_valid_o = pop;
  assign rsp_id_o    = fifo_mem_reg[rd_ptr_reg];

  always_comb begin
    gnt_o = '0;
    if (push) begin
      gnt_o[winner] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        rr_ptr_reg <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + IdxW'(1);
        wr_ptr_reg <= (wr_ptr_reg == PtrW'(Depth - 1)) ? '0 : wr_ptr_reg + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PtrW'(Depth - 1)) ? '0 : rd_ptr_reg + PtrW'(1);
      end
      // Push and pop together leave the occupancy unchanged, even when full.
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CntW'(1);
        2'b01:   count_reg <= count_reg - CntW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ID storage carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem_reg[wr_ptr_reg] <= winner;
    end
  end

endmodule

// File: rtl/carfield_l2_port_arbiter.sv
// carfield_l2_port_arbiter
//   Routes NumReq requesters onto two L2 ports selected by address. Each port
//   has its own round-robin scheduler and ID FIFO; out-of-range accesses are
//   accepted immediately and answered with an error on the following cycle.
//   Ports:
//     clk_i, rst_i                         : clock, async active-high reset
//     req_i/addr_i/we_i/wdata_i/be_i       : per-requester request
//     gnt_o/rvalid_o/rdata_o/err_o         : per-requester grant and response
//     l2_req_o/l2_addr_o/l2_we_o/
//       l2_wdata_o/l2_be_o                 : per-L2-port request (offset addr)
//     l2_gnt_i/l2_rvalid_i/l2_rdata_i      : per-L2-port grant and response
module carfield_l2_port_arbiter
  import carfield_l2arb_pkg::*;
#(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned IdFifoDepth = 4,
  parameter logic [63:0] L2Port0Base = carfield_configuration::CarfieldL2Port0Base,
  parameter logic [63:0] L2PortSize  = carfield_configuration::CarfieldL2PortSize,
  localparam int unsigned IdxW       = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumReq-1:0]                   req_i,
  input  logic [NumReq-1:0][63:0]             addr_i,
  input  logic [NumReq-1:0]                   we_i,
  input  logic [NumReq-1:0][63:0]             wdata_i,
  input  logic [NumReq-1:0][7:0]              be_i,
  output logic [NumReq-1:0]                   gnt_o,
  output logic [NumReq-1:0]                   rvalid_o,
  output logic [NumReq-1:0][63:0]             rdata_o,
  output logic [NumReq-1:0]                   err_o,
  output logic [1:0]                          l2_req_o,
  output logic [1:0][L2OffsetWidth-1:0]       l2_addr_o,
  output logic [1:0]                          l2_we_o,
  output logic [1:0][63:0]                    l2_wdata_o,
  output logic [1:0][7:0]                     l2_be_o,
  input  logic [1:0]                          l2_gnt_i,
  input  logic [1:0]                          l2_rvalid_i,
  input  logic [1:0][63:0]                    l2_rdata_i
);

  req_port_t               req_in    [NumReq];
  rsp_port_t               rsp_out   [NumReq];
  tgt_e                    tgt       [NumReq];
  l2_req_t                 l2_out    [2];
  l2_rsp_t                 l2_in     [2];
  logic [NumReq-1:0]       eligible;
  logic [NumReq-1:0]       oor_gnt;
  logic [1:0][NumReq-1:0]  port_req;
  logic [1:0][NumReq-1:0]  port_gnt;
  logic [1:0]              port_rsp_valid;
  logic [1:0][IdxW-1:0]    port_rsp_id;
  logic [1:0][IdxW-1:0]    port_winner;
  logic [NumReq-1:0]       busy_reg;
  logic [NumReq-1:0]       err_pend_reg;

  genvar gi;

  generate
    for (gi = 0; gi < int'(NumReq); gi++) begin : g_req
      assign req_in[gi] = '{req: req_i[gi], addr: addr_i[gi], we: we_i[gi],
                            wdata: wdata_i[gi], be: be_i[gi]};
      assign tgt[gi]    = decode_target(req_in[gi].addr, L2Port0Base, L2PortSize);
      // Outputs must stay quiet while reset is held, so reset gates eligibility.
      assign eligible[gi]    = req_in[gi].req & ~busy_reg[gi] & ~rst_i;
      assign port_req[0][gi] = eligible[gi] & (tgt[gi] == TGT_PORT0);
      assign port_req[1][gi] = eligible[gi] & (tgt[gi] == TGT_PORT1);
      assign oor_gnt[gi]     = eligible[gi] & (tgt[gi] == TGT_NONE);

      // At most one transaction per requester is in flight, so at most one
      // response source can target this requester in any cycle.
      always_comb begin
        rsp_out[gi]        = '0;
        rsp_out[gi].gnt    = port_gnt[0][gi] | port_gnt[1][gi] | oor_gnt[gi];
        rsp_out[gi].err    = err_pend_reg[gi];
        rsp_out[gi].rvalid = err_pend_reg[gi];
        if (port_rsp_valid[0] && (port_rsp_id[0] == IdxW'(gi))) begin
          rsp_out[gi].rvalid = 1'b1;
          rsp_out[gi].rdata  = l2_in[0].rdata;
        end else if (port_rsp_valid[1] && (port_rsp_id[1] == IdxW'(gi))) begin
          rsp_out[gi].rvalid = 1'b1;
          rsp_out[gi].rdata  = l2_in[1].rdata;
        end
      end

      assign gnt_o[gi]    = rsp_out[gi].gnt;
      assign rvalid_o[gi] = rsp_out[gi].rvalid;
      assign rdata_o[gi]  = rsp_out[gi].rdata;
      assign err_o[gi]    = rsp_out[gi].err;
    end
  endgenerate

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      localparam logic [63:0] PortBase = L2Port0Base + (64'(gi) * L2PortSize);

      assign l2_in[gi] = '{gnt: l2_gnt_i[gi], rvalid: l2_rvalid_i[gi],
                           rdata: l2_rdata_i[gi]};

      carfield_l2_port_sched #(
        .NumReq (NumReq),
        .Depth  (IdFifoDepth)
      ) i_sched (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (port_req[gi]),
        .gnt_o       (port_gnt[gi]),
        .req_o       (l2_out[gi].req),
        .winner_o    (port_winner[gi]),
        .l2_gnt_i    (l2_in[gi].gnt),
        .l2_rvalid_i (l2_in[gi].rvalid),
        .rsp_valid_o (port_rsp_valid[gi]),
        .rsp_id_o    (port_rsp_id[gi])
      );

      // Port windows are size-aligned, so the low offset bits of the
      // difference equal the difference of the low bits.
      assign l2_out[gi].addr  = req_in[port_winner[gi]].addr[L2OffsetWidth-1:0]
                              - PortBase[L2OffsetWidth-1:0];
      assign l2_out[gi].we    = req_in[port_winner[gi]].we;
      assign l2_out[gi].wdata = req_in[port_winner[gi]].wdata;
      assign l2_out[gi].be    = req_in[port_winner[gi]].be;

      assign l2_req_o[gi]   = l2_out[gi].req;
      assign l2_addr_o[gi]  = l2_out[gi].addr;
      assign l2_we_o[gi]    = l2_out[gi].we;
      assign l2_wdata_o[gi] = l2_out[gi].wdata;
      assign l2_be_o[gi]    = l2_out[gi].be;
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_reg     <= '0;
      err_pend_reg <= '0;
    end else begin
      busy_reg     <= (busy_reg | gnt_o) & ~rvalid_o;
      err_pend_reg <= oor_gnt;
    end
  end

endmodule

// File: tb/tb_carfield_l2_port_arbiter.sv
// tb_carfield_l2_port_arbiter
//   Directed checks of the L2 port arbiter with hand-computed expectations.
module tb_carfield_l2_port_arbiter;

  localparam int N = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic [N-1:0]         req_i;
  logic [N-1:0][63:0]   addr_i;
  logic [N-1:0]         we_i;
  logic [N-1:0][63:0]   wdata_i;
  logic [N-1:0][7:0]    be_i;
  logic [N-1:0]         gnt_o;
  logic [N-1:0]         rvalid_o;
  logic [N-1:0][63:0]   rdata_o;
  logic [N-1:0]         err_o;
  logic [1:0]           l2_req_o;
  logic [1:0][20:0]     l2_addr_o;
  logic [1:0]           l2_we_o;
  logic [1:0][63:0]     l2_wdata_o;
  logic [1:0][7:0]      l2_be_o;
  logic [1:0]           l2_gnt_i;
  logic [1:0]           l2_rvalid_i;
  logic [1:0][63:0]     l2_rdata_i;

  int n_cmp = 0;
  int n_mis = 0;

  carfield_l2_port_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .wdata_i     (wdata_i),
    .be_i        (be_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .l2_req_o    (l2_req_o),
    .l2_addr_o   (l2_addr_o),
    .l2_we_o     (l2_we_o),
    .l2_wdata_o  (l2_wdata_o),
    .l2_be_o     (l2_be_o),
    .l2_gnt_i    (l2_gnt_i),
    .l2_rvalid_i (l2_rvalid_i),
    .l2_rdata_i  (l2_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic clr();
    req_i       = '0;
    addr_i      = '0;
    we_i        = '0;
    wdata_i     = '0;
    be_i        = '0;
    l2_gnt_i    = 2'b11;
    l2_rvalid_i = '0;
    l2_rdata_i  = '0;
  endtask

  task automatic all_to(input logic [63:0] a);
    for (int i = 0; i < N; i++) addr_i[i] = a;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  int owner_order [4] = '{1, 2, 3, 0};

  initial begin
    // Reset state with every requester asking for port 0.
    clr();
    req_i = 4'hF;
    all_to(64'h7800_0040);
    #2;
    check("rst_gnt", 64'(gnt_o), 64'h0);
    check("rst_l2_req", 64'(l2_req_o), 64'h0);
    check("rst_rvalid", 64'(rvalid_o), 64'h0);
    check("rst_err", 64'(err_o), 64'h0);
    next_cycle();
    rst_i = 1'b0;
    clr();

    // All four to port 0: RR grants 0,1,2,3 one per cycle.
    req_i = 4'hF;
    all_to(64'h7800_0040);
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("rr_gnt_c%0d", c), 64'(gnt_o), 64'(1 << c));
      check($sformatf("rr_l2_req_c%0d", c), 64'(l2_req_o), 64'h1);
      check($sformatf("rr_l2_addr_c%0d", c), 64'(l2_addr_o[0]), 64'h40);
      next_cycle();
    end
    // Four outstanding: nothing more issued.
    #1;
    check("full_l2_req", 64'(l2_req_o), 64'h0);
    check("full_gnt", 64'(gnt_o), 64'h0);
    next_cycle();
    // One response goes to the first grantee.
    l2_rvalid_i = 2'b01;
    l2_rdata_i[0] = 64'hA0;
    #1;
    check("rsp0_rvalid", 64'(rvalid_o), 64'h1);
    check("rsp0_rdata", rdata_o[0], 64'hA0);
    check("rsp0_l2_req", 64'(l2_req_o), 64'h0);
    next_cycle();
    // Slot freed and requester 0 idle again: fifth request issued.
    l2_rvalid_i = 2'b00;
    l2_rdata_i = '0;
    #1;
    check("fifth_gnt", 64'(gnt_o), 64'h1);
    check("fifth_l2_req", 64'(l2_req_o), 64'h1);
    next_cycle();
    // Drain in order: owners 1,2,3,0.
    req_i = '0;
    l2_rvalid_i = 2'b01;
    for (int k = 0; k < 4; k++) begin
      l2_rdata_i[0] = 64'hB0 + 64'(k);
      #1;
      check($sformatf("drain_rvalid_%0d", k), 64'(rvalid_o), 64'(1 << owner_order[k]));
      check($sformatf("drain_rdata_%0d", k), rdata_o[owner_order[k]], 64'hB0 + 64'(k));
      if (k == 0) check("drain_rdata_idle", rdata_o[0], 64'h0);
      next_cycle();
    end
    // Empty FIFO: stray response ignored.
    #1;
    check("stray_rvalid", 64'(rvalid_o), 64'h0);
    next_cycle();
    clr();

    // Two ports in parallel, with write fields on port 1.
    req_i = 4'b0011;
    addr_i[0] = 64'h7800_0000;
    addr_i[1] = 64'h7820_0010;
    we_i[1] = 1'b1;
    wdata_i[1] = 64'hDEAD_BEEF;
    be_i[1] = 8'h0F;
    #1;
    check("dual_gnt", 64'(gnt_o), 64'h3);
    check("dual_l2_req", 64'(l2_req_o), 64'h3);
    check("dual_addr0", 64'(l2_addr_o[0]), 64'h0);
    check("dual_addr1", 64'(l2_addr_o[1]), 64'h10);
    check("dual_we1", 64'(l2_we_o[1]), 64'h1);
    check("dual_wdata1", l2_wdata_o[1], 64'hDEAD_BEEF);
    check("dual_be1", 64'(l2_be_o[1]), 64'h0F);
    next_cycle();
    clr();
    l2_rvalid_i = 2'b11;
    l2_rdata_i[0] = 64'h1111;
    l2_rdata_i[1] = 64'h2222;
    #1;
    check("dual_rvalid", 64'(rvalid_o), 64'h3);
    check("dual_rdata0", rdata_o[0], 64'h1111);
    check("dual_rdata1", rdata_o[1], 64'h2222);
    check("dual_err", 64'(err_o), 64'h0);
    next_cycle();
    clr();

    // Out-of-range request: same-cycle grant, error response next cycle.
    req_i = 4'b0100;
    addr_i[2] = 64'h8000_0000;
    #1;
    check("oor_gnt", 64'(gnt_o), 64'h4);
    check("oor_l2_req", 64'(l2_req_o), 64'h0);
    next_cycle();
    #1;
    check("oor_rvalid", 64'(rvalid_o), 64'h4);
    check("oor_err", 64'(err_o), 64'h4);
    check("oor_rdata", rdata_o[2], 64'h0);
    check("oor_busy_gnt", 64'(gnt_o), 64'h0);
    next_cycle();
    #1;
    check("oor_regnt", 64'(gnt_o), 64'h4);
    next_cycle();
    clr();
    #1;
    check("oor_err2", 64'(err_o), 64'h4);
    next_cycle();

    // Busy requester on port 0: no grant until the cycle after its rvalid.
    req_i = 4'b0010;
    addr_i[1] = 64'h7800_0100;
    #1;
    check("busy_gnt", 64'(gnt_o), 64'h2);
    check("busy_addr", 64'(l2_addr_o[0]), 64'h100);
    next_cycle();
    #1;
    check("busy_hold", 64'(gnt_o), 64'h0);
    next_cycle();
    l2_rvalid_i = 2'b01;
    l2_rdata_i[0] = 64'h77;
    #1;
    check("busy_rvalid", 64'(rvalid_o), 64'h2);
    check("busy_rdata", rdata_o[1], 64'h77);
    check("busy_rsp_gnt", 64'(gnt_o), 64'h0);
    next_cycle();
    l2_rvalid_i = 2'b00;
    #1;
    check("busy_regnt", 64'(gnt_o), 64'h2);
    next_cycle();
    clr();
    l2_rvalid_i = 2'b01;
    #1;
    check("busy_rvalid2", 64'(rvalid_o), 64'h2);
    next_cycle();
    clr();

    // Reset with two outstanding; pointer sits at 2 beforehand.
    req_i = 4'b0110;
    all_to(64'h7800_0200);
    #1;
    check("pre_rst_gnt_a", 64'(gnt_o), 64'h4);
    next_cycle();
    #1;
    check("pre_rst_gnt_b", 64'(gnt_o), 64'h2);
    next_cycle();
    rst_i = 1'b1;
    req_i = 4'hF;
    #1;
    check("mid_rst_gnt", 64'(gnt_o), 64'h0);
    check("mid_rst_l2_req", 64'(l2_req_o), 64'h0);
    next_cycle();
    rst_i = 1'b0;
    clr();
    l2_rvalid_i = 2'b01;
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("post_rst_rvalid_%0d", k), 64'(rvalid_o), 64'h0);
      next_cycle();
    end
    l2_rvalid_i = 2'b00;
    req_i = 4'hF;
    all_to(64'h7800_0000);
    #1;
    check("post_rst_gnt", 64'(gnt_o), 64'h1);
    next_cycle();
    clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
